// File: rtl/pcie_tx_lane_striper.sv
// rtl/pcie_tx_lane_striper.sv - transmit byte striper with frame FIFO, idle fill and SKP insertion
// Output registers always hold the beat currently presented to the lanes; each accepted beat computes the next one.
module pcie_tx_lane_striper #(
  parameter int  MAC_FRAME_WIDTH = 32,
  parameter int  NUM_LANES       = 4,
  parameter int  FIFO_DEPTH      = 4,
  parameter int  SKP_INTERVAL    = 1180,
  parameter int  SKP_LEN         = 3,
  localparam int LW              = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [MAC_FRAME_WIDTH-1:0]   mac_data_frame_i,
  input  logic                         mac_data_frame_valid_i,
  output logic                         mac_data_frame_ready_o,
  input  logic [LW-1:0]                link_width_log2_i,
  input  logic                         lane_ready_i,
  output logic [NUM_LANES*8-1:0]       lane_symbol_o,
  output logic [NUM_LANES-1:0]         lane_is_k_o,
  output logic [NUM_LANES-1:0]         lane_valid_o,
  output logic                         skp_pending_o,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level_o
);

  localparam int BYTES = MAC_FRAME_WIDTH / 8;
  localparam int MAXW  = $clog2(NUM_LANES);
  localparam int BW    = $clog2(BYTES) + 1;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CW    = $clog2(FIFO_DEPTH) + 1;
  localparam int SW    = $clog2(SKP_INTERVAL) + 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DATA = 2'd1;
  localparam logic [1:0] ST_COM  = 2'd2;
  localparam logic [1:0] ST_BODY = 2'd3;

  logic [MAC_FRAME_WIDTH-1:0] fifo_mem_q [FIFO_DEPTH];
  logic [AW-1:0]              wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]              fifo_cnt_q, fifo_cnt_d;
  logic                       ready_q, ready_d;
  logic                       push, pop;
  logic [1:0]                 state_q, state_d;
  logic [BW-1:0]              off_q, off_d;
  logic [LW-1:0]              wl_q, wl_d;
  logic [2:0]                 body_q, body_d;
  logic [SW-1:0]              beat_cnt_q, beat_cnt_d;
  logic                       skp_pend_q, skp_pend_d;
  logic [NUM_LANES*8-1:0]     sym_q, sym_d;
  logic [NUM_LANES-1:0]       isk_q, isk_d, vld_q, vld_d;
  logic [LW-1:0]              req_wl, wl_use;
  logic                       boundary;
  logic [MAC_FRAME_WIDTH-1:0] head;
  int                         w_lanes, base, nxt;

  assign push     = mac_data_frame_valid_i && ready_q;
  assign head     = fifo_mem_q[rd_ptr_q];
  assign req_wl   = (link_width_log2_i > LW'(MAXW)) ? LW'(MAXW) : link_width_log2_i;
  // Between frames: idle, a finished frame, or the last SKP symbol just sent.
  assign boundary = (state_q == ST_IDLE) ||
                    (state_q == ST_DATA && off_q == '0) ||
                    (state_q == ST_BODY && body_q == 3'(SKP_LEN));

  always_comb begin
    state_d    = state_q;
    off_d      = off_q;
    wl_d       = wl_q;
    body_d     = body_q;
    beat_cnt_d = beat_cnt_q;
    skp_pend_d = skp_pend_q;
    sym_d      = sym_q;
    isk_d      = isk_q;
    vld_d      = vld_q;
    pop        = 1'b0;
    wl_use     = boundary ? req_wl : wl_q;
    w_lanes    = 1 << wl_use;
    base       = boundary ? 0 : int'(off_q);
    nxt        = base + w_lanes;
    if (lane_ready_i) begin
      wl_d  = wl_use;
      sym_d = '0;
      isk_d = '0;
      for (int n = 0; n < NUM_LANES; n++) vld_d[n] = (n < w_lanes);
      if (beat_cnt_q == SW'(SKP_INTERVAL - 1)) skp_pend_d = 1'b1;
      else beat_cnt_d = beat_cnt_q + SW'(1);
      if (boundary && skp_pend_q) begin
        state_d    = ST_COM;
        off_d      = '0;
        beat_cnt_d = '0;
        skp_pend_d = 1'b0;
        for (int n = 0; n < NUM_LANES; n++) begin
          if (n < w_lanes) begin
            sym_d[8*n +: 8] = 8'hBC;
            isk_d[n]        = 1'b1;
          end
        end
      end else if (state_q == ST_COM || (state_q == ST_BODY && !boundary)) begin
        state_d = ST_BODY;
        body_d  = (state_q == ST_COM) ? 3'd1 : body_q + 3'd1;
        for (int n = 0; n < NUM_LANES; n++) begin
          if (n < w_lanes) begin
            sym_d[8*n +: 8] = 8'h1C;
            isk_d[n]        = 1'b1;
          end
        end
      end else if (!boundary || fifo_cnt_q != '0) begin
        state_d = ST_DATA;
        for (int n = 0; n < NUM_LANES; n++) begin
          if (n < w_lanes) sym_d[8*n +: 8] = head[8*(base+n) +: 8];
        end
        if (nxt >= BYTES) begin
          off_d = '0;
          pop   = 1'b1;
        end else begin
          off_d = BW'(nxt);
        end
      end else begin
        state_d = ST_IDLE;
        off_d   = '0;
      end
    end
  end

  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q;
    if (push && !pop)      fifo_cnt_d = fifo_cnt_q + CW'(1);
    else if (!push && pop) fifo_cnt_d = fifo_cnt_q - CW'(1);
    ready_d    = (fifo_cnt_d != CW'(FIFO_DEPTH));
  end

  always_ff @(posedge clk_i) begin
    if (push) fifo_mem_q[wr_ptr_q] <= mac_data_frame_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      ready_q    <= 1'b0;
      state_q    <= ST_IDLE;
      off_q      <= '0;
      wl_q       <= '0;
      body_q     <= '0;
      beat_cnt_q <= '0;
      skp_pend_q <= 1'b0;
      sym_q      <= '0;
      isk_q      <= '0;
      vld_q      <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
      ready_q    <= ready_d;
      state_q    <= state_d;
      off_q      <= off_d;
      wl_q       <= wl_d;
      body_q     <= body_d;
      beat_cnt_q <= beat_cnt_d;
      skp_pend_q <= skp_pend_d;
      sym_q      <= sym_d;
      isk_q      <= isk_d;
      vld_q      <= vld_d;
    end
  end

  assign mac_data_frame_ready_o = ready_q;
  assign lane_symbol_o          = sym_q;
  assign lane_is_k_o            = isk_q;
  assign lane_valid_o           = vld_q;
  assign skp_pending_o          = skp_pend_q;
  assign fifo_level_o           = fifo_cnt_q;

endmodule

// File: tb/tb_pcie_tx_lane_striper.sv
// tb/tb_pcie_tx_lane_striper.sv - self-checking bench for pcie_tx_lane_striper
// Reference model: frame queue plus a byte queue drained W bytes per beat, with SKP bookkeeping.
module tb_pcie_tx_lane_striper;
  localparam int NL = 4, FW = 32, DEPTH = 4, SKPI = 8, SKPL = 3, BYTES = FW / 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [FW-1:0]   frame = '0;
  logic            frame_valid = 1'b0;
  logic            frame_ready;
  logic [1:0]      width = 2'd0;
  logic            lane_ready = 1'b1;
  logic [NL*8-1:0] lane_symbol;
  logic [NL-1:0]   lane_is_k, lane_valid;
  logic            skp_pending;
  logic [2:0]      fifo_level;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pcie_tx_lane_striper #(
    .MAC_FRAME_WIDTH(FW), .NUM_LANES(NL), .FIFO_DEPTH(DEPTH),
    .SKP_INTERVAL(SKPI), .SKP_LEN(SKPL)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .mac_data_frame_i(frame), .mac_data_frame_valid_i(frame_valid),
    .mac_data_frame_ready_o(frame_ready), .link_width_log2_i(width),
    .lane_ready_i(lane_ready), .lane_symbol_o(lane_symbol),
    .lane_is_k_o(lane_is_k), .lane_valid_o(lane_valid),
    .skp_pending_o(skp_pending), .fifo_level_o(fifo_level)
  );

  wire [44:0] dut_vec = {lane_symbol, lane_is_k, lane_valid, frame_ready, skp_pending, fifo_level};

  logic [FW-1:0] m_frames[$];
  logic [7:0]    m_bytes[$];
  int            m_w, m_cnt, m_skp_rem, m_coms;
  bit            m_pend, m_ready;
  logic [NL*8-1:0] e_sym;
  logic [NL-1:0]   e_k, e_v;

  function automatic int clamp_w(logic [1:0] v);
    return (v > 2'd2) ? 4 : (1 << v);
  endfunction

  function automatic logic [44:0] exp_vec();
    return {e_sym, e_k, e_v, m_ready, m_pend, 3'(m_frames.size())};
  endfunction

  task automatic model_reset();
    m_frames.delete();
    m_bytes.delete();
    m_w = 1; m_cnt = 0; m_skp_rem = 0; m_pend = 0; m_ready = 0;
    e_sym = '0; e_k = '0; e_v = '0;
  endtask

  task automatic model_edge();
    bit was_ready;
    bit com;
    logic [FW-1:0] f;
    was_ready = m_ready;
    com = 0;
    if (lane_ready) begin
      e_sym = '0; e_k = '0; e_v = '0;
      if (m_skp_rem == 0 && m_bytes.size() == 0) begin
        m_w = clamp_w(width);
        if (m_pend) begin
          com = 1;
        end else if (m_frames.size() > 0) begin
          f = m_frames[0];
          for (int b = 0; b < BYTES; b++) m_bytes.push_back(f[8*b +: 8]);
        end
      end
      for (int n = 0; n < m_w; n++) e_v[n] = 1'b1;
      if (com) begin
        for (int n = 0; n < m_w; n++) begin e_sym[8*n +: 8] = 8'hBC; e_k[n] = 1'b1; end
        m_skp_rem = SKPL;
      end else if (m_skp_rem > 0) begin
        for (int n = 0; n < m_w; n++) begin e_sym[8*n +: 8] = 8'h1C; e_k[n] = 1'b1; end
        m_skp_rem--;
      end else if (m_bytes.size() > 0) begin
        for (int n = 0; n < m_w; n++) e_sym[8*n +: 8] = m_bytes.pop_front();
        if (m_bytes.size() == 0) m_frames.delete(0);
      end
      if (com) begin m_cnt = 0; m_pend = 0; m_coms++; end
      else if (m_cnt == SKPI - 1) m_pend = 1;
      else m_cnt++;
    end
    if (frame_valid && was_ready) m_frames.push_back(frame);
    m_ready = (m_frames.size() < DEPTH);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset(logic [1:0] w);
    rst_n = 1'b0; frame_valid = 1'b0; lane_ready = 1'b1; width = w;
    #1;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; width = 2'd2;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    checks++; if (lane_symbol !== '0) begin errors++; $display("FAIL reset_symbol: got %h exp 0", lane_symbol); end
    checks++; if (lane_valid !== '0 || lane_is_k !== '0) begin errors++; $display("FAIL reset_valid_k: got %b/%b exp 0/0", lane_valid, lane_is_k); end
    checks++; if (frame_ready !== 1'b0 || skp_pending !== 1'b0 || fifo_level !== 3'd0) begin
      errors++; $display("FAIL reset_ctrl: got rdy %b pend %b lvl %0d exp 0 0 0", frame_ready, skp_pending, fifo_level); end
    rst_n = 1'b1;
    tick();
    checks++; if (frame_ready !== 1'b1 || lane_valid !== 4'hF || lane_symbol !== '0) begin
      errors++; $display("FAIL reset_exit: got rdy %b vld %b sym %h exp 1 1111 0", frame_ready, lane_valid, lane_symbol); end
    checks++; if (dut_vec !== exp_vec()) begin errors++; $display("FAIL reset_exit_model: got %h exp %h", dut_vec, exp_vec()); end
  endtask

  task automatic test_x4_frame();
    do_reset(2'd2);
    tick();
    frame_valid = 1'b1; frame = 32'hDDCCBBAA;
    tick();
    frame_valid = 1'b0;
    tick();
    checks++; if (lane_symbol !== 32'hDDCCBBAA || lane_is_k !== 4'h0 || lane_valid !== 4'hF) begin
      errors++; $display("FAIL x4_beat: got %h k %b v %b exp ddccbbaa 0000 1111", lane_symbol, lane_is_k, lane_valid); end
    checks++; if (dut_vec !== exp_vec()) begin errors++; $display("FAIL x4_model: got %h exp %h", dut_vec, exp_vec()); end
    tick();
    checks++; if (lane_symbol !== '0 || lane_valid !== 4'hF || fifo_level !== 3'd0) begin
      errors++; $display("FAIL x4_idle: got %h v %b lvl %0d exp 0 1111 0", lane_symbol, lane_valid, fifo_level); end
  endtask

  task automatic test_x1_frame();
    logic [7:0] exp_b [4];
    exp_b = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    do_reset(2'd0);
    tick();
    frame_valid = 1'b1; frame = 32'hDDCCBBAA;
    tick();
    frame_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (lane_symbol !== {24'h0, exp_b[i]} || lane_valid !== 4'b0001 || lane_is_k !== 4'h0) begin
        errors++; $display("FAIL x1_beat%0d: got %h v %b exp %h v 0001", i, lane_symbol, lane_valid, exp_b[i]); end
      checks++; if (dut_vec !== exp_vec()) begin errors++; $display("FAIL x1_model: got %h exp %h", dut_vec, exp_vec()); end
    end
  endtask

  task automatic test_fifo_full();
    do_reset(2'd2);
    tick();
    lane_ready = 1'b0; frame_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      frame = $urandom();
      tick();
      checks++; if (dut_vec !== exp_vec()) begin errors++; $display("FAIL full_fill: got %h exp %h", dut_vec, exp_vec()); end
    end
    frame_valid = 1'b0;
    checks++; if (frame_ready !== 1'b0 || fifo_level !== 3'd4) begin
      errors++; $display("FAIL full_level: got rdy %b lvl %0d exp 0 4", frame_ready, fifo_level); end
    lane_ready = 1'b1;
    tick();
    checks++; if (frame_ready !== 1'b1 || fifo_level !== 3'd3) begin
      errors++; $display("FAIL full_first_pop: got rdy %b lvl %0d exp 1 3", frame_ready, fifo_level); end
    repeat (8) begin
      tick();
      checks++; if (dut_vec !== exp_vec()) begin errors++; $display("FAIL full_drain: got %h exp %h", dut_vec, exp_vec()); end
    end
  endtask

  task automatic test_skp();
    int first_pend = -1;
    int dut_coms = 0;
    int start_coms;
    do_reset(2'd1);
    start_coms = m_coms;
    frame_valid = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      frame = $urandom();
      tick();
      checks++; if (dut_vec !== exp_vec()) begin errors++; $display("FAIL skp_stream: got %h exp %h", dut_vec, exp_vec()); end
      if (skp_pending && first_pend < 0) first_pend = i;
      if (lane_is_k == 4'b0011 && lane_symbol == 32'h0000BCBC) dut_coms++;
    end
    frame_valid = 1'b0;
    repeat (12) begin
      tick();
      checks++; if (dut_vec !== exp_vec()) begin errors++; $display("FAIL skp_drain: got %h exp %h", dut_vec, exp_vec()); end
      if (lane_is_k == 4'b0011 && lane_symbol == 32'h0000BCBC) dut_coms++;
    end
    checks++; if (first_pend != 8) begin errors++; $display("FAIL skp_first_pending: got beat %0d exp 8", first_pend); end
    checks++; if (dut_coms == 0 || dut_coms != m_coms - start_coms) begin
      errors++; $display("FAIL skp_com_count: got %0d exp %0d", dut_coms, m_coms - start_coms); end
  endtask

  task automatic test_width_change();
    do_reset(2'd0);
    tick();
    frame_valid = 1'b1; frame = 32'h44332211;
    tick();
    frame = 32'h88776655;
    tick();
    frame_valid = 1'b0; width = 2'd2;
    tick();
    checks++; if (lane_symbol !== 32'h00000022 || lane_valid !== 4'b0001) begin
      errors++; $display("FAIL wchg_mid: got %h v %b exp 00000022 0001", lane_symbol, lane_valid); end
    repeat (2) begin
      tick();
      checks++; if (dut_vec !== exp_vec()) begin errors++; $display("FAIL wchg_model: got %h exp %h", dut_vec, exp_vec()); end
    end
    tick();
    checks++; if (lane_symbol !== 32'h88776655 || lane_valid !== 4'hF) begin
      errors++; $display("FAIL wchg_next: got %h v %b exp 88776655 1111", lane_symbol, lane_valid); end
  endtask

  task automatic test_reset_mid_skp();
    bit found = 0;
    int first_pend = -1;
    do_reset(2'd1);
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      checks++; if (dut_vec !== exp_vec()) begin errors++; $display("FAIL rskp_run: got %h exp %h", dut_vec, exp_vec()); end
      if (lane_symbol[7:0] == 8'h1C && lane_is_k[0]) found = 1;
    end
    checks++; if (!found) begin errors++; $display("FAIL rskp_body_seen: got 0 exp 1"); end
    rst_n = 1'b0;
    #1;
    model_reset();
    checks++; if (dut_vec !== '0) begin errors++; $display("FAIL rskp_async: got %h exp 0", dut_vec); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      checks++; if (dut_vec !== exp_vec()) begin errors++; $display("FAIL rskp_after: got %h exp %h", dut_vec, exp_vec()); end
      if (skp_pending && first_pend < 0) first_pend = i;
    end
    checks++; if (first_pend != 8) begin errors++; $display("FAIL rskp_restart: got beat %0d exp 8", first_pend); end
  endtask

  task automatic test_random();
    do_reset(2'd2);
    tick();
    for (int i = 0; i < 1500; i++) begin
      frame_valid = ($urandom_range(0, 1) == 1);
      frame       = $urandom();
      lane_ready  = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) width = 2'($urandom_range(0, 3));
      tick();
      checks++; if (dut_vec !== exp_vec()) begin errors++; $display("FAIL random_%0d: got %h exp %h", i, dut_vec, exp_vec()); end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    m_coms = 0;
    model_reset();
    test_reset();
    test_x4_frame();
    test_x1_frame();
    test_fifo_full();
    test_skp();
    test_width_change();
    test_reset_mid_skp();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
